one_hot_demux: RTL and testbench

//  Steers one valid/ready input stream to one of N output streams, chosen per

---
 rtl/one_hot_demux.sv | 112 +++++++++++
 tb/tb_one_hot_demux.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_hot_demux.sv
// One-hot scatter: steers a valid/ready stream to one of N output ports.
// Single hold register, full throughput. Illegal selects are dropped and counted.
module one_hot_demux #(
  parameter int WIDTH = 64,
  parameter int N     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_select,
  output logic             in_ready,
  output logic [N-1:0]     out_valid,
  output logic [WIDTH-1:0] out_data [N-1:0],
  input  logic [N-1:0]     out_ready,
  input  logic             err_clear,
  output logic             err_sticky,
  output logic [15:0]      err_count
);

  if (!(N == 1 || N == 2 || N == 4 || N == 8)) begin : g_bad_n
    $error("one_hot_demux: N must be 1, 2, 4 or 8");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_dest;
  logic [WIDTH-1:0] r_data;
  logic             r_sticky;
  logic [15:0]      r_count;

  logic             w_dest_ready;
  logic             w_accept;
  logic             w_legal;
  logic             w_drain;
  logic             w_load;
  logic             w_err_ev;
  logic             w_sticky_nxt;
  logic [15:0]      w_count_nxt;

  // r_dest is one-hot whenever FULL, so this picks out_ready[d]
  assign w_dest_ready = |(r_dest & out_ready);
  assign in_ready     = (r_state == EMPTY) | w_dest_ready;
  assign w_accept     = in_valid & in_ready;
  assign w_legal      = $onehot(in_select);
  assign w_drain      = (r_state == FULL) & w_dest_ready;
  assign w_err_ev     = w_accept & ~w_legal;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_accept && w_legal) begin
          w_state_nxt = FULL;
          w_load      = 1'b1;
        end
      end
      FULL: begin
        if (w_accept && w_legal) begin
          w_load = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = EMPTY;
        end
      end
    endcase
  end

  // a clear coincident with an illegal accept keeps that one event
  always_comb begin
    w_sticky_nxt = r_sticky;
    w_count_nxt  = r_count;
    if (err_clear) begin
      w_sticky_nxt = w_err_ev;
      w_count_nxt  = {15'd0, w_err_ev};
    end else if (w_err_ev) begin
      w_sticky_nxt = 1'b1;
      if (r_count != 16'hFFFF) begin
        w_count_nxt = r_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_dest   <= '0;
      r_data   <= '0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sticky <= w_sticky_nxt;
      r_count  <= w_count_nxt;
      if (w_load) begin
        r_dest <= in_select;
        r_data <= in_data;
      end
    end
  end

  assign out_valid  = (r_state == FULL) ? r_dest : '0;
  assign err_sticky = r_sticky;
  assign err_count  = r_count;

  for (genvar i = 0; i < N; i++) begin : g_out
    assign out_data[i] = r_data;
  end

endmodule

// File: tb/tb_one_hot_demux.sv
// Randomized and directed bench for one_hot_demux.
// Checks N=4, N=2 and N=1 instances against a queue-based reference.
module tb_one_hot_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // N=4 instance
  logic        v4 = 0, c4 = 0, ir4, es4;
  logic [3:0]  s4 = 0, r4 = 0, ov4;
  logic [63:0] d4 = 0;
  logic [63:0] od4 [3:0];
  logic [15:0] ec4;

  // N=2 instance
  logic        v2 = 0, c2 = 0, ir2, es2;
  logic [1:0]  s2 = 0, r2 = 0, ov2;
  logic [63:0] d2 = 0;
  logic [63:0] od2 [1:0];
  logic [15:0] ec2;

  // N=1 instance
  logic        v1 = 0, c1 = 0, ir1, es1;
  logic        s1 = 0, r1 = 0, ov1;
  logic [63:0] d1 = 0;
  logic [63:0] od1 [0:0];
  logic [15:0] ec1;

  one_hot_demux #(.WIDTH(64), .N(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4),
    .in_select(s4), .in_ready(ir4), .out_valid(ov4),
    .out_data(od4), .out_ready(r4), .err_clear(c4),
    .err_sticky(es4), .err_count(ec4)
  );

  one_hot_demux #(.WIDTH(64), .N(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2),
    .in_select(s2), .in_ready(ir2), .out_valid(ov2),
    .out_data(od2), .out_ready(r2), .err_clear(c2),
    .err_sticky(es2), .err_count(ec2)
  );

  one_hot_demux #(.WIDTH(64), .N(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1),
    .in_select(s1), .in_ready(ir1), .out_valid(ov1),
    .out_data(od1), .out_ready(r1), .err_clear(c1),
    .err_sticky(es1), .err_count(ec1)
  );

  typedef struct {
    int          port;
    logic [63:0] data;
  } beat_t;

  task automatic drive4(input logic v, input logic [3:0] s,
                        input logic [63:0] d, input logic [3:0] rdy,
                        input logic clr);
    @(negedge clk);
    v4 = v; s4 = s; d4 = d; r4 = rdy; c4 = clr;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ov4 !== 4'b0) $display("FAIL rst_ov: got %b want 0000", ov4);
    else passed++;
    checks++;
    if (ec4 !== 16'd0 || es4 !== 1'b0)
      $display("FAIL rst_err: got %0d/%b want 0/0", ec4, es4);
    else passed++;
    checks++;
    if (od4[3] !== 64'd0) $display("FAIL rst_data: got %h want 0", od4[3]);
    else passed++;
    @(negedge clk); rst = 0;
    #1;
    checks++;
    if (ir4 !== 1'b1) $display("FAIL rst_ir: got %b want 1", ir4);
    else passed++;
    // one illegal beat, then hold a beat with the consumer stalled
    drive4(1, 4'b0000, 64'h0, 4'b0000, 0); step();
    drive4(1, 4'b0001, 64'hDEAD, 4'b0000, 0); step();
    drive4(0, 4'b0000, 64'h0, 4'b0000, 0);
    #1;
    checks++;
    if (ov4 !== 4'b0001 || ec4 !== 16'd1)
      $display("FAIL pre_rst: got %b/%0d want 0001/1", ov4, ec4);
    else passed++;
    #2 rst = 1;
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 4'b0 || ec4 !== 16'd0 || od4[0] !== 64'd0)
      $display("FAIL mid_rst: got %b/%0d/%h want 0000/0/0",
               ov4, ec4, od4[0]);
    else passed++;
    @(negedge clk); rst = 0;
    #1;
    checks++;
    if (ir4 !== 1'b1) $display("FAIL post_rst_ir: got %b want 1", ir4);
    else passed++;
  endtask

  task automatic test_streaming;
    logic [63:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = 64'hA0A0_0000_0000_0000 + 64'(i);
    for (int i = 0; i < 4; i++) begin
      drive4(1, 4'(1 << i), a[i], 4'b1111, 0);
      #1;
      checks++;
      if (ir4 !== 1'b1) $display("FAIL stream_ir%0d: got %b want 1", i, ir4);
      else passed++;
      step();
      checks++;
      if (ov4 !== 4'(1 << i) || od4[i] !== a[i])
        $display("FAIL stream%0d: got %b/%h want %b/%h",
                 i, ov4, od4[i], 4'(1 << i), a[i]);
      else passed++;
    end
    drive4(0, 4'b0, 64'h0, 4'b1111, 0); step();
    checks++;
    if (ov4 !== 4'b0) $display("FAIL stream_end: got %b want 0000", ov4);
    else passed++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    v2 = 1; s2 = 2'b10; d2 = 64'hB0; r2 = 2'b01;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v2 = 1; s2 = 2'b01; d2 = 64'hB1; r2 = 2'b01;
      #1;
      checks++;
      if (ir2 !== 1'b0) $display("FAIL bp_ir%0d: got %b want 0", i, ir2);
      else passed++;
      step();
      checks++;
      if (ov2 !== 2'b10 || od2[1] !== 64'hB0)
        $display("FAIL bp_hold%0d: got %b/%h want 10/b0", i, ov2, od2[1]);
      else passed++;
    end
    @(negedge clk);
    r2 = 2'b11;
    #1;
    checks++;
    if (ir2 !== 1'b1) $display("FAIL bp_release_ir: got %b want 1", ir2);
    else passed++;
    step();
    checks++;
    if (ov2 !== 2'b01 || od2[0] !== 64'hB1)
      $display("FAIL bp_reload: got %b/%h want 01/b1", ov2, od2[0]);
    else passed++;
    @(negedge clk); v2 = 0;
    step();
    checks++;
    if (ov2 !== 2'b00) $display("FAIL bp_drain: got %b want 00", ov2);
    else passed++;
  endtask

  task automatic test_illegal;
    drive4(0, 4'b0, 64'h0, 4'b1111, 1); step();
    drive4(1, 4'b0000, 64'hC0, 4'b1111, 0); step();
    checks++;
    if (ov4 !== 4'b0 || ec4 !== 16'd1 || es4 !== 1'b1)
      $display("FAIL ill_zero: got %b/%0d/%b want 0000/1/1", ov4, ec4, es4);
    else passed++;
    drive4(1, 4'b0110, 64'hC1, 4'b1111, 0); step();
    checks++;
    if (ov4 !== 4'b0 || ec4 !== 16'd2)
      $display("FAIL ill_multi: got %b/%0d want 0000/2", ov4, ec4);
    else passed++;
    drive4(1, 4'b0100, 64'hC2, 4'b1111, 0); step();
    checks++;
    if (ov4 !== 4'b0100 || od4[2] !== 64'hC2 || ec4 !== 16'd2 || es4 !== 1'b1)
      $display("FAIL ill_legal: got %b/%h/%0d want 0100/c2/2",
               ov4, od4[2], ec4);
    else passed++;
    drive4(0, 4'b0, 64'h0, 4'b1111, 0); step();
  endtask

  task automatic test_clear_race;
    for (int i = 0; i < 3; i++) begin
      drive4(1, 4'b1111, 64'h0, 4'b1111, 0); step();
    end
    checks++;
    if (ec4 !== 16'd5) $display("FAIL clr_pre: got %0d want 5", ec4);
    else passed++;
    drive4(1, 4'b0000, 64'h0, 4'b1111, 1); step();
    checks++;
    if (ec4 !== 16'd1 || es4 !== 1'b1)
      $display("FAIL clr_race: got %0d/%b want 1/1", ec4, es4);
    else passed++;
    drive4(0, 4'b0, 64'h0, 4'b1111, 1); step();
    checks++;
    if (ec4 !== 16'd0 || es4 !== 1'b0)
      $display("FAIL clr_only: got %0d/%b want 0/0", ec4, es4);
    else passed++;
    drive4(0, 4'b0, 64'h0, 4'b1111, 0); step();
  endtask

  task automatic test_random;
    beat_t       q[$];
    beat_t       b;
    int          cnt = 0;
    logic        st = 0;
    logic        v, clr, exp_ir, acc, legal, ill;
    logic [3:0]  s, rdy, exp_ov;
    logic [63:0] d;
    int          p;
    drive4(0, 4'b0, 64'h0, 4'b1111, 1); step();
    repeat (400) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) s = 4'($urandom);
      else s = 4'(1 << $urandom_range(0, 3));
      d = {$urandom, $urandom};
      rdy = 4'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      drive4(v, s, d, rdy, clr);
      exp_ir = (q.size() == 0) || rdy[q[0].port];
      #1;
      checks++;
      if (ir4 !== exp_ir)
        $display("FAIL rnd_ir: got %b want %b", ir4, exp_ir);
      else passed++;
      acc = v && exp_ir;
      legal = ($countones(s) == 1);
      ill = acc && !legal;
      if (q.size() != 0 && rdy[q[0].port]) b = q.pop_front();
      if (acc && legal) begin
        p = 0;
        for (int k = 0; k < 4; k++) if (s[k]) p = k;
        q.push_back('{port: p, data: d});
      end
      if (clr) begin
        cnt = ill ? 1 : 0;
        st = ill;
      end else if (ill) begin
        st = 1;
        if (cnt < 65535) cnt++;
      end
      step();
      exp_ov = (q.size() != 0) ? 4'(1 << q[0].port) : 4'b0;
      checks++;
      if (ov4 !== exp_ov || (q.size() != 0 && od4[q[0].port] !== q[0].data))
        $display("FAIL rnd_out: got %b want %b", ov4, exp_ov);
      else passed++;
      checks++;
      if (ec4 !== 16'(cnt) || es4 !== st)
        $display("FAIL rnd_err: got %0d/%b want %0d/%b", ec4, es4, cnt, st);
      else passed++;
    end
    drive4(0, 4'b0, 64'h0, 4'b1111, 0); step();
  endtask

  task automatic test_saturation;
    drive4(0, 4'b0, 64'h0, 4'b1111, 1); step();
    drive4(1, 4'b0000, 64'h0, 4'b1111, 0);
    repeat (65536) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ec4 !== 16'hFFFF || es4 !== 1'b1)
      $display("FAIL sat: got %h/%b want ffff/1", ec4, es4);
    else passed++;
    step();
    checks++;
    if (ec4 !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", ec4);
    else passed++;
    drive4(0, 4'b0, 64'h0, 4'b1111, 0); step();
  endtask

  task automatic test_n1;
    logic [63:0] d;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      @(negedge clk);
      v1 = 1; s1 = 1; d1 = d; r1 = 1;
      #1;
      checks++;
      if (ir1 !== 1'b1) $display("FAIL n1_ir%0d: got %b want 1", i, ir1);
      else passed++;
      step();
      checks++;
      if (ov1 !== 1'b1 || od1[0] !== d)
        $display("FAIL n1_pass%0d: got %b/%h want 1/%h", i, ov1, od1[0], d);
      else passed++;
    end
    @(negedge clk);
    v1 = 1; s1 = 0;
    step();
    checks++;
    if (ov1 !== 1'b0 || ec1 !== 16'd1 || es1 !== 1'b1)
      $display("FAIL n1_ill: got %b/%0d/%b want 0/1/1", ov1, ec1, es1);
    else passed++;
    @(negedge clk); v1 = 0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_illegal();
    test_clear_race();
    test_random();
    test_saturation();
    test_n1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
